// File: rtl/fetch_next_pc.sv
// Fetch / next-PC stage wrapped around the external PC register.
// One Avalon-MM instruction read per instruction. The word is presented to
// decode in ISSUE. Taken branches/jumps redirect after one delay slot.
// Fetch stops permanently (until reset) when the PC reaches HALT_ADDR.
module fetch_next_pc #(
    parameter logic [31:0] HALT_ADDR   = 32'h0000_0000,
    parameter bit          ENDIAN_SWAP = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,
    input  logic [31:0] pc_in,
    output logic [31:0] pc_next,
    output logic        pc_advance,
    output logic [31:0] imem_address,
    output logic        imem_read,
    input  logic        imem_waitrequest,
    input  logic [31:0] imem_readdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        active
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_ISSUE  = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        pending_q, pending_d;
    logic [31:0] target_q, target_d;

    logic        at_halt_s;
    logic        read_s;
    logic        read_done_s;
    logic        advance_s;
    logic [31:0] fetch_word_s;

    function automatic logic [31:0] byte_reverse(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    assign at_halt_s    = (pc_in == HALT_ADDR);
    assign fetch_word_s = ENDIAN_SWAP ? byte_reverse(imem_readdata) : imem_readdata;
    assign imem_address = {pc_in[31:2], 2'b00};

    // State register: reset drops any in-flight read and returns to FETCH.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: read completion is honoured regardless of clk_enable.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (at_halt_s) begin
                    state_d = S_HALTED;
                end else if (!imem_waitrequest) begin
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_ISSUE: begin
                if (clk_enable) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_FETCH;
        endcase
    end

    // Output decode: the read request and advance strobe are masked during reset.
    always_comb begin
        read_s      = 1'b0;
        advance_s   = 1'b0;
        instr_valid = 1'b0;
        active      = 1'b1;
        case (state_q)
            S_FETCH: begin
                read_s = !at_halt_s && !reset;
            end
            S_ISSUE: begin
                instr_valid = 1'b1;
                advance_s   = clk_enable && !reset;
            end
            S_HALTED: begin
                active = 1'b0;
            end
            default: begin
                read_s = 1'b0;
            end
        endcase
    end

    assign imem_read   = read_s;
    assign pc_advance  = advance_s;
    assign read_done_s = read_s && !imem_waitrequest;

    // Datapath next-state: capture fetched word, and track the delayed redirect.
    always_comb begin
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        pending_d  = pending_q;
        target_d   = target_q;
        pc_next    = pc_in + 32'd4;
        if (read_done_s) begin
            instr_d    = fetch_word_s;
            instr_pc_d = pc_in;
        end else begin
            instr_d    = instr_q;
        end
        if (pending_q) begin
            // The current instruction is the delay slot; the target follows it.
            pc_next = target_q;
            if (advance_s) begin
                pending_d = 1'b0;
            end else begin
                pending_d = 1'b1;
            end
        end else begin
            // A redirect on a delay-slot instruction never reaches here, so it is dropped.
            if (advance_s && redirect_valid) begin
                pending_d = 1'b1;
                target_d  = redirect_target;
            end else begin
                pending_d = 1'b0;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q    <= 32'd0;
            instr_pc_q <= 32'd0;
            pending_q  <= 1'b0;
            target_q   <= 32'd0;
        end else begin
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            pending_q  <= pending_d;
            target_q   <= target_d;
        end
    end

    assign instr    = instr_q;
    assign instr_pc = instr_pc_q;

endmodule

// File: tb/tb_fetch_next_pc.sv
// Randomised bench for fetch_next_pc: models the PC register and memory,
// keeps an instruction-level model of the expected fetch sequence and
// checks issued instructions through a scoreboard queue.
module tb_fetch_next_pc;

    localparam logic [31:0] RESET_VEC = 32'hBFC0_0000;
    localparam logic [31:0] HALT      = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset, clk_enable;
    logic [31:0] pc_in, pc_next;
    logic        pc_advance;
    logic [31:0] imem_address;
    logic        imem_read, imem_waitrequest;
    logic [31:0] imem_readdata;
    logic [31:0] instr, instr_pc;
    logic        instr_valid;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        active;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] exp_pc_q[$];
    logic [31:0] exp_ins_q[$];

    logic [31:0] m_pc, m_target;
    logic        m_pending, m_halted;
    int          halt_age = 0;

    always #5 clk = ~clk;

    fetch_next_pc dut (
        .clk(clk), .reset(reset), .clk_enable(clk_enable),
        .pc_in(pc_in), .pc_next(pc_next), .pc_advance(pc_advance),
        .imem_address(imem_address), .imem_read(imem_read),
        .imem_waitrequest(imem_waitrequest), .imem_readdata(imem_readdata),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .active(active)
    );

    // External PC register (PC_1).
    always @(posedge clk) begin
        if (reset) pc_in <= RESET_VEC;
        else if (pc_advance) pc_in <= pc_next;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] swapped(input logic [31:0] w);
        logic [31:0] r;
        r = {<<8{w}};
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push_expect(input logic [31:0] a);
        exp_pc_q.push_back(a);
        exp_ins_q.push_back(swapped(mem_word(a)));
    endtask

    // Stimulus: random enables, stalls, redirects and occasional resets.
    initial begin
        int wait_run;
        int ce_run;
        wait_run = 0;
        ce_run   = 0;
        reset = 1'b1; clk_enable = 1'b0; imem_waitrequest = 1'b1;
        imem_readdata = 32'd0; redirect_valid = 1'b0; redirect_target = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            reset = (halt_age >= 6) || ($urandom_range(0, 249) == 0);
            clk_enable = ($urandom_range(0, 3) != 0) || (ce_run >= 4);
            ce_run = clk_enable ? 0 : ce_run + 1;
            imem_waitrequest = ($urandom_range(0, 9) < 4) && (wait_run < 4);
            wait_run = imem_waitrequest ? wait_run + 1 : 0;
            imem_readdata = imem_waitrequest ? $urandom : mem_word(imem_address);
            redirect_valid = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 19))
                0:       redirect_target = 32'h0000_0000;
                1:       redirect_target = 32'hFFFF_FFF8;
                default: redirect_target = {16'hBFC0, 14'($urandom), 2'b00};
            endcase
        end
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Monitor, scoreboard and instruction-level reference model.
    initial begin
        logic        prev_reset, prev_valid, prev_acc, prev_hold, prev_adv, prev_wait;
        logic [31:0] held_ins, held_pc, held_addr, nxt;
        int          idle;
        prev_reset = 1'b1; prev_valid = 1'b0; prev_acc = 1'b0;
        prev_hold = 1'b0; prev_adv = 1'b0; prev_wait = 1'b0;
        held_ins = 32'd0; held_pc = 32'd0; held_addr = 32'd0; idle = 0;
        m_pc = RESET_VEC; m_target = 32'd0; m_pending = 1'b0; m_halted = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                exp_pc_q.delete();
                exp_ins_q.delete();
                m_pc = RESET_VEC; m_pending = 1'b0; m_halted = 1'b0; halt_age = 0;
                push_expect(RESET_VEC);
                prev_reset = 1'b1; prev_valid = 1'b0; prev_acc = 1'b0;
                prev_hold = 1'b0; prev_adv = 1'b0; prev_wait = 1'b0; idle = 0;
            end else begin
                if (prev_reset) begin
                    chk1("reset_instr_valid", instr_valid, 1'b0);
                    chk("reset_instr", instr, 32'd0);
                    chk("reset_instr_pc", instr_pc, 32'd0);
                    chk1("reset_active", active, 1'b1);
                    chk1("reset_pc_advance", pc_advance, 1'b0);
                    chk1("reset_read", imem_read, 1'b1);
                    chk("reset_address", imem_address, RESET_VEC);
                end
                if (imem_read && instr_valid) chk1("read_during_issue", imem_read, 1'b0);
                if (prev_acc) chk1("valid_after_read", instr_valid, 1'b1);
                if (prev_hold) begin
                    chk1("hold_valid", instr_valid, 1'b1);
                    chk("hold_instr", instr, held_ins);
                    chk("hold_instr_pc", instr_pc, held_pc);
                end
                if (prev_adv) chk1("valid_drop_after_advance", instr_valid, 1'b0);
                if (prev_wait) begin
                    chk1("read_held_in_wait", imem_read, 1'b1);
                    chk("address_held_in_wait", imem_address, held_addr);
                end
                chk1("pc_advance", pc_advance, instr_valid && clk_enable);
                if (instr_valid && !prev_valid) begin
                    idle = 0;
                    if (exp_pc_q.size() == 0) begin
                        chk("unexpected_issue", instr_pc, 32'hDEAD_DEAD);
                    end else begin
                        chk("issue_pc", instr_pc, exp_pc_q.pop_front());
                        chk("issue_instr", instr, exp_ins_q.pop_front());
                    end
                end else if (!m_halted) begin
                    idle++;
                    if (idle > 60) begin
                        chk1("issue_timeout", 1'b0, 1'b1);
                        idle = 0;
                    end
                end
                if (m_halted) begin
                    chk1("halt_no_read", imem_read, 1'b0);
                    chk1("halt_no_valid", instr_valid, 1'b0);
                    if (halt_age >= 1) chk1("halt_inactive", active, 1'b0);
                    halt_age++;
                end
                if (pc_advance) begin
                    if (m_pending) begin
                        nxt = m_target;
                        m_pending = 1'b0;
                    end else begin
                        nxt = m_pc + 32'd4;
                        if (redirect_valid) begin
                            m_pending = 1'b1;
                            m_target = redirect_target;
                        end
                    end
                    chk("pc_next", pc_next, nxt);
                    m_pc = nxt;
                    if (m_pc == HALT) m_halted = 1'b1;
                    else push_expect(m_pc);
                end
                prev_reset = 1'b0;
                prev_valid = instr_valid;
                prev_acc   = imem_read && !imem_waitrequest;
                prev_hold  = instr_valid && !clk_enable;
                prev_adv   = pc_advance;
                prev_wait  = imem_read && imem_waitrequest;
                held_ins   = instr;
                held_pc    = instr_pc;
                held_addr  = imem_address;
            end
        end
    end

endmodule
